alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one `alu` instance between NUM_REQ requesters, e.g. the execute stage and a branch/address unit.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The granted operation is evaluated combinationally by the internal `alu`, then captured in a single-entry response register.
- The response register carries the result and the requester ID, with downstream valid/ready backpressure.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester ID.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant; request accepted when valid & ready.
- req_operand1  input  NUM_REQ x 32  per-requester operand1.
- req_operand2  input  NUM_REQ x 32  per-requester operand2.
- req_operation  input  NUM_REQ x 4  per-requester {imm7[5], imm3} code.
- resp_valid  output  1  response register holds a result.
- resp_ready  input  1  consumer accepts the response.
- resp_result  output  32  ALU result of the accepted request.
- resp_id  output  ID_W  index of the requester that issued it.

Behaviour:
- Reset (synchronous, active-high, checked every edge) values:
  - resp_valid=0, resp_result=0, resp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 during reset.
- Reset mid-transaction discards any held response. No acceptance occurs on a reset cycle.
- State: EMPTY (resp_valid=0) / FULL (resp_valid=1).
- space = !resp_valid | resp_ready.
- Grant rules:
  - When space=1 and any req_valid=1, exactly one req_ready bit is 1.
  - It selects the first valid requester at or after rr_ptr, scanning upward with wrap-around from NUM_REQ-1 to 0.
  - When space=0 or no request is valid, req_ready is all zero.
- req_ready may depend combinationally on req_valid and resp_ready. Requesters must not make req_valid depend on req_ready.
- On acceptance of requester k (req_valid[k] & req_ready[k]) at edge t:
  - resp_result <= alu(operand1[k], operand2[k], operation[k]).
  - resp_id <= k; resp_valid <= 1.
  - rr_ptr <= (k+1) mod NUM_REQ.
- Latency: a request accepted at edge t has its response visible from t+ (1 cycle).
- Simultaneous drain and accept (FULL & resp_ready & some valid): the old response retires and the new one loads in the same edge. Full throughput is 1 op/cycle.
- Drain without accept: resp_valid <= 0. resp_result and resp_id hold their last values (don't-care).
- FULL & !resp_ready: resp_result and resp_id are held stable. No grants are issued.
- Requester stability: payload must stay stable while valid & !ready. A requester may drop valid before it is granted.
- Unsupported operation codes yield result 0, the ALU default. The request is still accepted and answered.
- rr_ptr changes only on acceptance.
- Starvation-free: any requester held valid is granted within NUM_REQ accepted transactions.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not implemented, and requester 0 can starve the others.
- Undefined (default): round-robin as specified above.
- Handshake and latency are identical in both modes.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t (logic [3:0]).
  - localparams for the op codes: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- Natural sub-module: rr_arbiter, a pure grant generator. Inputs are req, ptr and enable; output is a one-hot grant.
- The existing `alu` is instantiated once, unchanged.

Test Plan:
- Reset with req_valid=11 asserted → resp_valid=0, resp_result=0, resp_id=0, req_ready=00 during reset. After reset deasserts, the first grant is req_ready=01.
- NUM_REQ=2, both valid every cycle, resp_ready=1. Req0 issues ADD 5+7, req1 issues SUB 3-5.
  - Grants alternate 01,10,01,…
  - Responses alternate resp_id 0 → 12 and resp_id 1 → 0xFFFFFFFE.
  - One result per cycle.
- Backpressure: resp_ready=0 for 3 cycles while FULL with SRA 0x80000000>>>4.
  - resp_result holds 0xF8000000 and req_ready=00 throughout.
  - On resp_ready=1 the next request is accepted in the same edge.
- Only req1 valid, with SLTU 1<0xFFFFFFFF → req_ready=10 and resp_result=1, resp_id=1. rr_ptr wraps so req0 gets priority next.
- Undefined op 4'b1001 with operands 9,9 → accepted; resp_result=0, resp_valid=1.
- With ALU_ARB_FIXED_PRIO_EN defined, both requesters held valid and resp_ready=1 → req_ready=01 every cycle, and req1 is never granted.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and the ALU-sharing arbiter.
//   alu_op_t      4-bit operation code, {imm7[5], imm3}
//   ALU_*         operation code constants
//   resp_state_t  occupancy state of the single-entry response register
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_t;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit integer ALU.
//   operand1  in  32  first operand
//   operand2  in  32  second operand (low 5 bits are the shift amount)
//   operation in  4   {imm7[5], imm3} operation code
//   result    out 32  result; unsupported codes give 0
module alu
    import alu_pkg::*;
(
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  alu_op_t     operation,
    output logic [31:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = operand2[4:0];

    // Operation decode and evaluation.
    always_comb begin
        result = 32'd0;
        case (operation)
            ALU_ADD:  result = operand1 + operand2;
            ALU_SUB:  result = operand1 - operand2;
            ALU_SLL:  result = operand1 << shamt_s;
            ALU_SLT:  result = {31'd0, ($signed(operand1) < $signed(operand2))};
            ALU_SLTU: result = {31'd0, (operand1 < operand2)};
            ALU_XOR:  result = operand1 ^ operand2;
            ALU_SRL:  result = operand1 >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(operand1) >>> shamt_s);
            ALU_OR:   result = operand1 | operand2;
            ALU_AND:  result = operand1 & operand2;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: pure combinational round-robin grant generator.
//   req    in  NUM_REQ  request vector
//   ptr    in  ID_W     highest-priority index for this decision
//   enable in  1        when low, no grant is issued
//   grant  out NUM_REQ  one-hot grant (all zero if disabled or no request)
// The winner is the first requester at or above ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] upper_s;

    // Lowest set bit of a vector, as a one-hot vector.
    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        logic               found;
        r     = {NUM_REQ{1'b0}};
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (v[j] && !found) begin
                r[j]  = 1'b1;
                found = 1'b1;
            end else begin
                r[j]  = r[j];
            end
        end
        return r;
    endfunction

    // Requests at or above the pointer get first pick; otherwise wrap around.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            upper_s[j] = req[j] & (ID_W'(j) >= ptr);
        end
    end

    // Grant selection.
    always_comb begin
        grant = {NUM_REQ{1'b0}};
        if (!enable) begin
            grant = {NUM_REQ{1'b0}};
        end else if (|upper_s) begin
            grant = lowest_set(upper_s);
        end else begin
            grant = lowest_set(req);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ valid/ready requesters.
// The granted request is evaluated combinationally and captured in a
// single-entry response register with downstream valid/ready backpressure.
//   clk           in  1            clock
//   reset         in  1            synchronous active-high reset
//   req_valid     in  NUM_REQ      per-requester valid
//   req_ready     out NUM_REQ      one-hot grant (combinational)
//   req_operand1  in  NUM_REQ x 32 operand1 per requester
//   req_operand2  in  NUM_REQ x 32 operand2 per requester
//   req_operation in  NUM_REQ x 4  operation code per requester
//   resp_valid    out 1            response register full
//   resp_ready    in  1            consumer takes the response
//   resp_result   out 32           captured ALU result
//   resp_id       out ID_W         index of the requester that issued it
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins
// priority instead of round-robin (no pointer register is built).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_operand1,
    input  logic [NUM_REQ-1:0][31:0] req_operand2,
    input  logic [NUM_REQ-1:0][3:0]  req_operation,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_result,
    output logic [ID_W-1:0]         resp_id
);

    resp_state_t        state_r;
    resp_state_t        state_next_s;
    logic               space_s;
    logic               arb_en_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               accept_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [ID_W-1:0]    ptr_s;
    logic [31:0]        sel_op1_s;
    logic [31:0]        sel_op2_s;
    alu_op_t            sel_op_s;
    logic [31:0]        alu_result_s;
    logic [31:0]        resp_result_r;
    logic [ID_W-1:0]    resp_id_r;

    // The register can take a new entry when empty or when draining this edge.
    assign space_s  = (state_r == ST_EMPTY) | resp_ready;
    assign arb_en_s = space_s & ~reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_s),
        .enable (arb_en_s),
        .grant  (grant_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |(req_valid & grant_s);

    // One-hot AND-OR mux: grant index and the winner's payload.
    always_comb begin
        grant_idx_s = {ID_W{1'b0}};
        sel_op1_s   = 32'd0;
        sel_op2_s   = 32'd0;
        sel_op_s    = 4'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_idx_s = grant_idx_s | ({ID_W{grant_s[j]}} & ID_W'(j));
            sel_op1_s   = sel_op1_s | ({32{grant_s[j]}} & req_operand1[j]);
            sel_op2_s   = sel_op2_s | ({32{grant_s[j]}} & req_operand2[j]);
            sel_op_s    = sel_op_s  | ({4{grant_s[j]}}  & req_operation[j]);
        end
    end

    alu u_alu (
        .operand1  (sel_op1_s),
        .operand2  (sel_op2_s),
        .operation (sel_op_s),
        .result    (alu_result_s)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at requester 0.
    assign ptr_s = {ID_W{1'b0}};
`else
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] rr_ptr_next_s;

    // Pointer moves to the requester after the one just accepted.
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (!accept_s) begin
            rr_ptr_next_s = rr_ptr_r;
        end else if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next_s = {ID_W{1'b0}};
        end else begin
            rr_ptr_next_s = grant_idx_s + ID_W'(1'b1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    assign ptr_s = rr_ptr_r;
`endif

    // Response occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy next state: accept wins over drain so both can happen at once.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else if (resp_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Response payload register; holds its value unless a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_result_r <= 32'd0;
            resp_id_r     <= {ID_W{1'b0}};
        end else if (accept_s) begin
            resp_result_r <= alu_result_s;
            resp_id_r     <= grant_idx_s;
        end else begin
            resp_result_r <= resp_result_r;
            resp_id_r     <= resp_id_r;
        end
    end

    assign resp_valid  = (state_r == ST_FULL);
    assign resp_result = resp_result_r;
    assign resp_id     = resp_id_r;

endmodule
